picobello_eoc_mailbox: RTL and testbench
========================================

PICOBELLO_EOC_MAILBOX -- requirements
Module: picobello_eoc_mailbox

Interface
REQ-001 SHALL have parameter DrainCycles, default 16, meaning consecutive UART-idle cycles required before end-of-computation is flagged (range 1..65535).
REQ-002 SHALL have parameter TimeoutCycles, default 0, meaning watchdog limit in cycles while IDLE (0 = disabled, 32-bit value).
REQ-003 SHALL have port clk_i  input  1  the only clock.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid_i input 1 / req_ready_o output 1  request handshake.
REQ-006 SHALL have ports req_write_i input 1, req_addr_i input 4, req_wdata_i input 32  request payload; req_addr_i is a byte address, bits [1:0] ignored.
REQ-007 SHALL have ports rsp_valid_o output 1 / rsp_ready_i input 1  response handshake.
REQ-008 SHALL have ports rsp_rdata_o output 32, rsp_error_o output 1  response payload.
REQ-009 SHALL have port uart_busy_i  input  1  UART transmitter/receiver mid-byte.
REQ-010 SHALL have ports eoc_o output 1, timeout_o output 1, exit_code_o output 32  completion status to the chip pads / bench.

Function
REQ-011 SHALL implement FSM states IDLE, DRAIN, DONE, TIMEOUT; reset state IDLE.
REQ-012 Register map SHALL be: 0x0 EOC (R/W), 0x4 STATUS (RO: bits[1:0] state IDLE=0, DRAIN=1, DONE=2, TIMEOUT=3; bit2 = uart_busy_i), 0x8 DRAINCNT (RO: current drain counter, zero-extended); any other address -> rsp_error_o=1, rsp_rdata_o=0.
REQ-013 req_ready_o SHALL equal ~rsp_valid_o; a request is accepted when req_valid_i & req_ready_o.
REQ-014 Response SHALL appear with rsp_valid_o=1 exactly one cycle after acceptance and hold rsp_rdata_o/rsp_error_o stable until rsp_valid_o & rsp_ready_i, after which rsp_valid_o drops the next cycle.
REQ-015 EOC write in IDLE with wdata[0]=1 SHALL latch code = wdata[31:1] and move to DRAIN at the next edge; response error=0.
REQ-016 EOC write in IDLE with wdata[0]=0 SHALL be ignored with error=0 (scratch behaviour, no state change).
REQ-017 EOC write in DRAIN, DONE or TIMEOUT SHALL be ignored with error=1 (first completion wins).
REQ-018 Write to 0x4 or 0x8 SHALL have no effect and return error=1.
REQ-019 EOC read SHALL return {code, done} where done=1 in DRAIN/DONE, else 0; code resets to 0.
REQ-020 In DRAIN the drain counter SHALL increment each cycle uart_busy_i=0, clear to 0 on any cycle uart_busy_i=1, and on reaching DrainCycles move to DONE the next edge.
REQ-021 The drain counter SHALL be 0 outside DRAIN and SHALL saturate, never wrap.
REQ-022 In IDLE with TimeoutCycles!=0 a 32-bit watchdog SHALL count every cycle; on reaching TimeoutCycles move to TIMEOUT; an EOC done-write in the same cycle as expiry SHALL win (go DRAIN).
REQ-023 eoc_o SHALL be 1 exactly in DONE and TIMEOUT; timeout_o SHALL be 1 exactly in TIMEOUT.
REQ-024 exit_code_o SHALL be {1'b0, code} in DONE, 32'hFFFF_FFFF in TIMEOUT, 0 otherwise.
REQ-025 DONE and TIMEOUT SHALL be terminal until reset.
REQ-026 All outputs SHALL be registered (no combinational path from inputs to outputs except req_ready_o from rsp_valid_o state).

Reset
REQ-027 On rst_ni=0 all state SHALL clear asynchronously: state IDLE, code 0, counters 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_error_o 0, eoc_o 0, timeout_o 0, exit_code_o 0, req_ready_o 1.
REQ-028 Reset asserted mid-DRAIN or mid-response SHALL abort the transaction with no further response after release.

Verification
REQ-029 Write 0x0 = 0x0000_0001, uart_busy_i=0, DrainCycles=16 -> state DRAIN, eoc_o=1 exactly 16 cycles after DRAIN entry + 1, exit_code_o=0.
REQ-030 Write 0x0 = 0x0000_0007, toggle uart_busy_i high at drain count 10 for 3 cycles -> counter clears, eoc_o rises 16 idle cycles after busy drops, exit_code_o=3.
REQ-031 After DONE, write 0x0 = 0x0000_0005 -> rsp_error_o=1, exit_code_o unchanged at 3; read 0x4 -> 0x2.
REQ-032 TimeoutCycles=100, no writes -> eoc_o=1, timeout_o=1, exit_code_o=0xFFFF_FFFF at cycle 100; done-write landing on cycle 100 instead -> DRAIN.
REQ-033 Hold rsp_ready_i=0 for 5 cycles after a read of 0xC -> rsp_valid_o, rsp_error_o=1, rsp_rdata_o=0 stable, req_ready_o=0 throughout.
REQ-034 Assert rst_ni=0 mid-DRAIN -> all outputs at reset values immediately; after release, read 0x0 -> 0x0.

Source files
------------

// File: rtl/picobello_eoc_mailbox.sv
// picobello end-of-computation mailbox: latches the exit code, waits for
// the UART to drain, then raises eoc; optional idle watchdog.
module picobello_eoc_mailbox #(
  parameter int unsigned DrainCycles   = 16,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [3:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  input  logic        uart_busy_i,
  output logic        eoc_o,
  output logic        timeout_o,
  output logic [31:0] exit_code_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  localparam logic [15:0] DrainMax = 16'(DrainCycles);
  localparam logic [31:0] WdogLast = 32'(TimeoutCycles) - 32'd1;
  localparam bit          WdogEn   = (TimeoutCycles != 0);

  state_e      state_q, state_d;
  logic [30:0] code_q, code_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] wdog_q, wdog_d;
  logic [1:0]  word;
  logic        accept;
  logic        done_wr;
  logic        done_flag;
  logic [31:0] rdata_d;
  logic        error_d;
  logic        unused_addr;

  assign unused_addr = ^req_addr_i[1:0];
  assign word        = req_addr_i[3:2];
  assign req_ready_o = ~rsp_valid_o;
  assign accept      = req_valid_i & req_ready_o;
  assign done_flag   = (state_q == DRAIN) | (state_q == DONE);
  assign done_wr     = accept & req_write_i & (word == 2'd0)
                     & req_wdata_i[0] & (state_q == IDLE);

  always_comb begin
    rdata_d = '0;
    error_d = 1'b0;
    unique case (1'b1)
      (word == 2'd0): begin
        if (req_write_i) error_d = (state_q != IDLE);
        else             rdata_d = {code_q, done_flag};
      end
      (word == 2'd1): begin
        if (req_write_i) error_d = 1'b1;
        else             rdata_d = {29'd0, uart_busy_i, state_q};
      end
      (word == 2'd2): begin
        if (req_write_i) error_d = 1'b1;
        else             rdata_d = {16'd0, cnt_q};
      end
      default: error_d = 1'b1;
    endcase
  end

  // counters read as zero outside the state that owns them
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = '0;
    wdog_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (done_wr) begin
          state_d = DRAIN;
          code_d  = req_wdata_i[31:1];
        end else if (WdogEn) begin
          if (wdog_q == WdogLast) state_d = TIMEOUT;
          else                    wdog_d  = wdog_q + 32'd1;
        end
      end
      DRAIN: begin
        if (cnt_q >= DrainMax)  state_d = DONE;
        else if (!uart_busy_i)  cnt_d   = cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      code_q      <= '0;
      cnt_q       <= '0;
      wdog_q      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
      eoc_o       <= 1'b0;
      timeout_o   <= 1'b0;
      exit_code_o <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
      eoc_o     <= (state_d == DONE) | (state_d == TIMEOUT);
      timeout_o <= (state_d == TIMEOUT);
      if (state_d == DONE)         exit_code_o <= {1'b0, code_d};
      else if (state_d == TIMEOUT) exit_code_o <= 32'hFFFF_FFFF;
      else                         exit_code_o <= '0;
      if (accept) begin
        rsp_valid_o <= 1'b1;
        rsp_rdata_o <= rdata_d;
        rsp_error_o <= error_d;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_picobello_eoc_mailbox.sv
// Self-checking bench for picobello_eoc_mailbox: register table,
// multi-cycle corner sequences and a randomized run against a model.
module tb_picobello_eoc_mailbox;

  localparam int DRAIN = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;
  logic        busy = 1'b0;

  logic        req_ready, rsp_valid, rsp_error, eoc, tmo;
  logic [31:0] rsp_rdata, exit_code;
  logic        to_req_ready, to_rsp_valid, to_rsp_error, to_eoc, to_tmo;
  logic [31:0] to_rsp_rdata, to_exit_code;

  always #5 clk = ~clk;

  picobello_eoc_mailbox #(.DrainCycles(DRAIN), .TimeoutCycles(0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .uart_busy_i(busy),
    .eoc_o(eoc), .timeout_o(tmo), .exit_code_o(exit_code)
  );

  picobello_eoc_mailbox #(.DrainCycles(DRAIN), .TimeoutCycles(100)) dut_to (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(to_req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(to_rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(to_rsp_rdata), .rsp_error_o(to_rsp_error),
    .uart_busy_i(busy),
    .eoc_o(to_eoc), .timeout_o(to_tmo), .exit_code_o(to_exit_code)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    busy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic xact(input logic w, input logic [3:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("xact_rsp_valid", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_error;
    @(posedge clk); #1;
  endtask

  // behavioural model: state 0 idle, 1 draining, 2 done
  int          m_state;
  int          m_cnt;
  logic [30:0] m_code;
  logic        m_rv, m_wr, m_re;
  logic [31:0] m_rd;

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_code = '0;
    m_rv = 1'b0; m_wr = 1'b0; m_re = 1'b0; m_rd = '0;
  endtask

  task automatic model_edge();
    logic       acc;
    logic [1:0] w;
    int         ns, ncnt;
    logic [30:0] nc;
    acc = req_valid && !m_rv;
    w = req_addr[3:2];
    ns = m_state; nc = m_code; ncnt = 0;
    if (acc) begin
      m_wr = req_write; m_rd = '0; m_re = 1'b0;
      if (w == 2'd0 && req_write) m_re = (m_state != 0);
      else if (w == 2'd0) m_rd = {m_code, (m_state == 1 || m_state == 2)};
      else if (w == 2'd1 && !req_write)
        m_rd = 32'(m_state) + (busy ? 32'd4 : 32'd0);
      else if (w == 2'd2 && !req_write) m_rd = 32'(m_cnt);
      else m_re = 1'b1;
    end
    if (acc) m_rv = 1'b1;
    else if (m_rv && rsp_ready) m_rv = 1'b0;
    if (m_state == 0 && acc && req_write && w == 2'd0 && req_wdata[0]) begin
      ns = 1;
      nc = req_wdata[31:1];
    end else if (m_state == 1) begin
      if (m_cnt >= DRAIN) ns = 2;
      else if (!busy) ncnt = m_cnt + 1;
    end
    m_state = ns;
    m_code = nc;
    m_cnt = (ns == 1) ? ncnt : 0;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;
    int          pct;

    vt[0]  = '{1'b0, 4'h0, 32'h0,  1'b0, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 4'h4, 32'h0,  1'b0, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 4'h8, 32'h0,  1'b0, 32'h0, 1'b0};
    vt[3]  = '{1'b0, 4'hC, 32'h0,  1'b0, 32'h0, 1'b1};
    vt[4]  = '{1'b1, 4'h4, 32'h1,  1'b0, 32'h0, 1'b1};
    vt[5]  = '{1'b1, 4'h8, 32'h1,  1'b0, 32'h0, 1'b1};
    vt[6]  = '{1'b1, 4'h0, 32'h10, 1'b0, 32'h0, 1'b0};
    vt[7]  = '{1'b0, 4'h0, 32'h0,  1'b0, 32'h0, 1'b0};
    vt[8]  = '{1'b0, 4'h5, 32'h0,  1'b1, 32'h4, 1'b0};
    vt[9]  = '{1'b1, 4'h0, 32'h7,  1'b1, 32'h0, 1'b0};
    vt[10] = '{1'b0, 4'h0, 32'h0,  1'b1, 32'h7, 1'b0};
    vt[11] = '{1'b0, 4'h6, 32'h0,  1'b1, 32'h5, 1'b0};
    vt[12] = '{1'b1, 4'h2, 32'h9,  1'b1, 32'h0, 1'b1};
    vt[13] = '{1'b0, 4'h8, 32'h0,  1'b1, 32'h0, 1'b0};
    vt[14] = '{1'b0, 4'h0, 32'h0,  1'b1, 32'h7, 1'b0};
    vt[15] = '{1'b1, 4'hC, 32'h3,  1'b1, 32'h0, 1'b1};

    // reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_eoc", 32'(eoc), 32'd0);
    chk("rst_timeout", 32'(tmo), 32'd0);
    chk("rst_exit", exit_code, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // register table
    for (int i = 0; i < 16; i++) begin
      busy = vt[i].busy;
      xact(vt[i].wr, vt[i].addr, vt[i].wdata, rd, er);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(vt[i].err));
      if (!vt[i].wr)
        chk($sformatf("tbl%0d_rdata", i), rd, vt[i].rdata);
    end

    // plain drain, uart idle
    do_reset();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h0; req_wdata = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("drain_eoc_low", 32'(eoc), 32'd0);
    n = 0;
    while (!eoc && n < 60) begin @(posedge clk); #1; n++; end
    chk("drain_latency", 32'(n), 32'd17);
    chk("drain_exit", exit_code, 32'd0);
    chk("drain_timeout", 32'(tmo), 32'd0);

    // drain interrupted by uart activity at count 10
    do_reset();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h0; req_wdata = 32'h7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    busy = 1'b0;
    n = 13;
    while (!eoc && n < 80) begin @(posedge clk); #1; n++; end
    chk("busy_latency", 32'(n), 32'd30);
    chk("busy_exit", exit_code, 32'd3);
    xact(1'b1, 4'h0, 32'h5, rd, er);
    chk("late_write_err", 32'(er), 32'd1);
    chk("late_write_exit", exit_code, 32'd3);
    xact(1'b0, 4'h4, 32'h0, rd, er);
    chk("done_status", rd, 32'd2);
    chk("done_eoc_held", 32'(eoc), 32'd1);

    // watchdog expiry
    do_reset();
    n = 0;
    while (!to_eoc && n < 200) begin @(posedge clk); #1; n++; end
    chk("wdog_latency", 32'(n), 32'd100);
    chk("wdog_timeout", 32'(to_tmo), 32'd1);
    chk("wdog_exit", to_exit_code, 32'hFFFF_FFFF);
    chk("wdog_off_eoc", 32'(eoc), 32'd0);
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("wdog_terminal", 32'(to_tmo), 32'd1);

    // done-write on the expiry cycle wins
    do_reset();
    for (int i = 0; i < 99; i++) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h0; req_wdata = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("race_timeout", 32'(to_tmo), 32'd0);
    chk("race_eoc", 32'(to_eoc), 32'd0);
    n = 0;
    while (!to_eoc && n < 60) begin @(posedge clk); #1; n++; end
    chk("race_latency", 32'(n), 32'd17);
    chk("race_done_tmo", 32'(to_tmo), 32'd0);
    chk("race_exit", to_exit_code, 32'd0);

    // response held under back-pressure
    do_reset();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'hC; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_error", 32'(rsp_error), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drop_valid", 32'(rsp_valid), 32'd0);
    chk("bp_drop_ready", 32'(req_ready), 32'd1);

    // reset mid-drain with a response pending
    do_reset();
    xact(1'b1, 4'h0, 32'hFF, rd, er);
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_pending", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_rdata", rsp_rdata, 32'd0);
    chk("abort_error", 32'(rsp_error), 32'd0);
    chk("abort_eoc", 32'(eoc), 32'd0);
    chk("abort_exit", exit_code, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    xact(1'b0, 4'h0, 32'h0, rd, er);
    chk("abort_eoc_reg", rd, 32'd0);
    xact(1'b0, 4'h4, 32'h0, rd, er);
    chk("abort_status", rd, 32'd0);

    // randomized traffic against the model
    for (int ep = 0; ep < 24; ep++) begin
      do_reset();
      model_reset();
      pct = (ep % 3 == 0) ? 0 : ((ep % 3 == 1) ? 5 : 30);
      for (int cyc = 0; cyc < 80; cyc++) begin
        req_valid = ($urandom_range(0, 99) < 50);
        req_write = $urandom_range(0, 1) == 1;
        req_addr = 4'($urandom_range(0, 15));
        req_wdata = $urandom;
        if ($urandom_range(0, 3) == 0) begin
          req_write = 1'b1;
          req_addr = 4'h0;
        end
        rsp_ready = ($urandom_range(0, 99) < 70);
        busy = ($urandom_range(0, 99) < pct);
        model_edge();
        @(posedge clk); #1;
        chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rnd_req_ready", 32'(req_ready), 32'(!m_rv));
        chk("rnd_eoc", 32'(eoc), 32'(m_state >= 2));
        chk("rnd_timeout", 32'(tmo), 32'd0);
        chk("rnd_exit", exit_code,
            (m_state == 2) ? {1'b0, m_code} : 32'd0);
        if (m_rv) chk("rnd_rsp_error", 32'(rsp_error), 32'(m_re));
        if (m_rv && !m_wr) chk("rnd_rsp_rdata", rsp_rdata, m_rd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
